mult_rr_scheduler: RTL and testbench

// - Shares one sequential shift-add multiplier (start/ready, N-bit operands, 2N-bit product)

---
 rtl/mult_rr_scheduler.sv | 138 +++++++++++++
 tb/tb_mult_rr_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: round-robin front end that time-shares one sequential multiplier
// among NREQ requesters, returning each product tagged with its requester index.
`default_nettype none

module mult_rr_scheduler #(
  parameter int N       = 4,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*N-1:0]        req_a,
  input  logic [NREQ*N-1:0]        req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [2*N-1:0]           rsp_product,
  output logic                     busy,
  output logic                     err,
  output logic                     mul_start,
  output logic [N-1:0]             mul_multiplicand,
  output logic [N-1:0]             mul_multiplier,
  input  logic                     mul_ready,
  input  logic [2*N-1:0]           mul_product
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] w_grant_id;
  logic [IDW-1:0] w_ptr_next;
  logic [IDW:0]   w_cand;
  logic           w_grant_found;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [2*N-1:0] r_product;
  logic [CW-1:0]  r_wait_cnt;
  logic           r_err;
  logic           w_timeout;

  // Scan from the pointer upward, wrapping; the extra bit of w_cand absorbs the wrap.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    w_cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_cand >= (IDW+1)'(NREQ))
        w_cand = w_cand - (IDW+1)'(NREQ);
      if (!w_grant_found && req_valid[w_cand[IDW-1:0]]) begin
        w_grant_found = 1'b1;
        w_grant_id    = w_cand[IDW-1:0];
      end
    end
  end

  assign w_ptr_next = (w_grant_id == IDW'(NREQ - 1)) ? '0 : w_grant_id + 1'b1;
  assign w_timeout  = (r_state == S_WAIT) && !mul_ready &&
                      (r_wait_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_found)            w_state_next = S_ISSUE;
      S_ISSUE:                               w_state_next = S_WAIT;
      S_WAIT:  if (mul_ready || w_timeout)   w_state_next = S_RESP;
      S_RESP:  if (rsp_ready)                w_state_next = S_IDLE;
      default:                               w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_id       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_product  <= '0;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_grant_found) begin
            r_id  <= w_grant_id;
            r_ptr <= w_ptr_next;
            r_a   <= req_a[w_grant_id*N +: N];
            r_b   <= req_b[w_grant_id*N +: N];
          end
        end
        S_ISSUE: r_wait_cnt <= '0;
        S_WAIT: begin
          // A late mul_ready on the timeout cycle still wins over the error path.
          if (mul_ready) begin
            r_product <= mul_product;
          end else if (w_timeout) begin
            r_product <= '0;
            r_err     <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Gated by rst_n so no accept pulse can escape while reset is asserted.
  assign req_ready = (rst_n && (r_state == S_IDLE) && w_grant_found) ?
                     (NREQ'(1) << w_grant_id) : '0;

  assign rsp_valid        = (r_state == S_RESP);
  assign rsp_id           = r_id;
  assign rsp_product      = r_product;
  assign busy             = (r_state != S_IDLE);
  assign err              = r_err;
  assign mul_start        = (r_state == S_ISSUE);
  assign mul_multiplicand = r_a;
  assign mul_multiplier   = r_b;

endmodule

`default_nettype wire

// File: tb/tb_mult_rr_scheduler.sv
// tb_mult_rr_scheduler: directed stimulus with a response scoreboard and a shift-add multiplier model.
`default_nettype none

module tb_mult_rr_scheduler;

  localparam int N       = 4;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*N-1:0]   req_a;
  logic [NREQ*N-1:0]   req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [1:0]          rsp_id;
  logic [2*N-1:0]      rsp_product;
  logic                busy;
  logic                err;
  logic                mul_start;
  logic [N-1:0]        mul_multiplicand;
  logic [N-1:0]        mul_multiplier;
  logic                mul_ready;
  logic [2*N-1:0]      mul_product;

  always #5 clk = ~clk;

  mult_rr_scheduler #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_product(rsp_product),
    .busy(busy), .err(err),
    .mul_start(mul_start), .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_ready(mul_ready), .mul_product(mul_product)
  );

  // Multiplier model: start sampled at edge E, one-cycle ready pulse visible N+1 cycles later.
  logic           stub_dead;
  logic           m_busy;
  logic [2:0]     m_cnt;
  logic [N-1:0]   m_a, m_b;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy      <= 1'b0;
      m_cnt       <= '0;
      mul_ready   <= 1'b0;
      mul_product <= '0;
    end else begin
      mul_ready <= 1'b0;
      if (mul_start) begin
        m_busy <= 1'b1;
        m_cnt  <= 3'(N);
        m_a    <= mul_multiplicand;
        m_b    <= mul_multiplier;
      end else if (m_busy) begin
        if (m_cnt == 3'd1) begin
          m_busy <= 1'b0;
          if (!stub_dead) begin
            mul_ready   <= 1'b1;
            mul_product <= {4'b0, m_a} * {4'b0, m_b};
          end
        end else begin
          m_cnt <= m_cnt - 3'd1;
        end
      end
    end
  end

  typedef struct {
    logic [1:0]     id;
    logic [2*N-1:0] prod;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int id, input int prod);
    exp_t e;
    e.id   = 2'(id);
    e.prod = 8'(prod);
    exp_q.push_back(e);
  endtask

  // Monitor: every response handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id %0d product %0d, expected no response",
                 rsp_id, rsp_product);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        check("rsp_product", 32'(rsp_product), 32'(mon_e.prod));
      end
    end
  end

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_a[i*N +: N] = N'(a);
    req_b[i*N +: N] = N'(b);
    req_valid[i]    = 1'b1;
  endtask

  // Waits for the next accept pulse, checks it, then drops that requester's valid.
  task automatic wait_grant(input int idx, input string name);
    int k;
    k = 0;
    #1;
    while (req_ready == '0 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(name, 32'(req_ready), 32'(1 << idx));
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    int c;
    int starts;
    logic err_early;

    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    stub_dead = 1'b0;
    err_early = 1'b0;

    // Reset state
    do_reset();
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_mul_start", 32'(mul_start), 0);
    check("rst_req_ready", 32'(req_ready), 0);

    // Test 1: single request, latency
    set_req(1, 3, 5);
    push(1, 15);
    #1;
    check("t1_ready_c0", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("t1_start_c1", 32'(mul_start), 1);
    check("t1_mcand", 32'(mul_multiplicand), 3);
    check("t1_mplier", 32'(mul_multiplier), 5);
    check("t1_busy", 32'(busy), 1);
    c = 1;
    starts = 0;
    do begin
      @(negedge clk);
      c++;
      if (mul_start) starts++;
    end while (!rsp_valid && c < 40);
    check("t1_rsp_cycle", 32'(c), 7);
    check("t1_single_start", 32'(starts), 0);
    wait_idle("t1_idle");

    // Test 2: all requesters, order 0,1,2,3,0
    do_reset();
    set_req(0, 2, 3);  set_req(1, 4, 5);  set_req(2, 6, 7);  set_req(3, 8, 9);
    push(0, 6);  push(1, 20);  push(2, 42);  push(3, 72);  push(0, 63);
    wait_grant(0, "t2_grant0");
    set_req(0, 7, 9);
    wait_grant(1, "t2_grant1");
    wait_grant(2, "t2_grant2");
    wait_grant(3, "t2_grant3");
    wait_grant(0, "t2_grant0_again");
    wait_idle("t2_idle");

    // Test 3: wrap from pointer 3 to requester 0, then 2
    do_reset();
    set_req(2, 3, 3);
    push(2, 9);
    wait_grant(2, "t3_first2");
    wait_idle("t3_idle_a");
    set_req(0, 1, 13);  set_req(2, 2, 2);
    push(0, 13);  push(2, 4);
    wait_grant(0, "t3_wrap0");
    wait_grant(2, "t3_then2");
    wait_idle("t3_idle_b");

    // Test 4: backpressure holds 225 with no new accept
    set_req(3, 15, 15);
    push(3, 225);
    wait_grant(3, "t4_grant3");
    rsp_ready = 1'b0;
    set_req(1, 2, 9);
    push(1, 18);
    c = 0;
    while (!rsp_valid && c < 40) begin
      @(negedge clk);
      c++;
    end
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(rsp_valid), 1);
      check("t4_hold_product", 32'(rsp_product), 225);
      check("t4_hold_id", 32'(rsp_id), 3);
      check("t4_no_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_grant(1, "t4_grant1_after");
    wait_idle("t4_idle");

    // Test 5: dead multiplier -> timeout, sticky err
    stub_dead = 1'b1;
    set_req(0, 2, 3);
    push(0, 0);
    check("t5_err_before", 32'(err), 0);
    wait_grant(0, "t5_grant0");
    @(negedge clk);
    check("t5_start", 32'(mul_start), 1);
    c = 1;
    while (!rsp_valid && c < 100) begin
      @(negedge clk);
      c++;
      if (c == 65) err_early = err;
    end
    check("t5_rsp_cycle", 32'(c), 66);
    check("t5_err_early", 32'(err_early), 0);
    check("t5_err_set", 32'(err), 1);
    check("t5_product_zero", 32'(rsp_product), 0);
    wait_idle("t5_idle_a");
    stub_dead = 1'b0;
    set_req(1, 3, 4);
    push(1, 12);
    wait_grant(1, "t5_grant1");
    wait_idle("t5_idle_b");
    check("t5_err_sticky", 32'(err), 1);

    // Test 6: reset during WAIT abandons the op
    set_req(0, 5, 5);
    wait_grant(0, "t6_grant0");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_busy", 32'(busy), 0);
    check("t6_rsp_valid", 32'(rsp_valid), 0);
    check("t6_err_cleared", 32'(err), 0);
    check("t6_mul_start", 32'(mul_start), 0);
    check("t6_mcand", 32'(mul_multiplicand), 0);
    check("t6_mplier", 32'(mul_multiplier), 0);
    check("t6_rsp_id", 32'(rsp_id), 0);
    check("t6_rsp_product", 32'(rsp_product), 0);
    check("t6_req_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_still_idle", 32'(busy), 0);
    set_req(3, 6, 7);
    push(3, 42);
    wait_grant(3, "t6_grant3");
    wait_idle("t6_idle");

    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
